reg_xfer_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the bank of 4-bit load-enabled registers in the register-transfer datapath. It accepts one transfer command at a time over a valid/ready handshake and executes it by driving the shared data bus and the per-register load strobes. Supported commands are MOVE, LOAD immediate, CLEAR and a three-step SWAP through an internal temporary register. It reads the current register contents back through a flattened input and never holds datapath state except the SWAP temporary.

---
 rtl/reg_xfer_ctrl_if.sv | 40 ++++
 rtl/reg_xfer_ctrl.sv | 151 +++++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_xfer_ctrl_if
//  Description : Command handshake and register-bank bus bundle shared by the
//                transfer controller and whatever issues commands to it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_xfer_ctrl_if #(
    parameter int NREG = 4,
    parameter int W    = 4
) ();
    localparam int SELW = $clog2(NREG);

    // Command channel
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [SELW-1:0]     req_src;
    logic [SELW-1:0]     req_dst;
    logic [W-1:0]        req_imm;

    // Register bank side
    logic [NREG*W-1:0]   reg_q;
    logic [W-1:0]        bus;
    logic [NREG-1:0]     load;
    logic                done;

    // Command issuer / register bank owner
    modport master (
        output req_valid, req_op, req_src, req_dst, req_imm, reg_q,
        input  req_ready, bus, load, done
    );

    // Transfer controller
    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_imm, reg_q,
        output req_ready, bus, load, done
    );
endinterface
`default_nettype wire

// File: rtl/reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_xfer_ctrl
//  Description : Sequencing controller for a bank of load-enabled registers.
//                Executes MOVE, LOAD immediate, CLEAR and a three-step SWAP
//                by driving the shared data bus and one-hot load strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_xfer_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    reg_xfer_ctrl_if.slave  xif
);
    localparam int SELW = $clog2(NREG);

    // FSM encoding
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EXEC = 3'd1;
    localparam logic [2:0] SW1  = 3'd2;
    localparam logic [2:0] SW2  = 3'd3;
    localparam logic [2:0] SW3  = 3'd4;

    // Command opcodes
    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [1:0]      r_op;
    logic [SELW-1:0] r_src;
    logic [SELW-1:0] r_dst;
    logic [W-1:0]    r_imm;
    logic [W-1:0]    r_tmp;
    logic            r_done;

    logic            w_accept;
    logic [W-1:0]    w_regs [NREG];
    logic [W-1:0]    w_src_q;
    logic [W-1:0]    w_dst_q;
    logic [NREG-1:0] w_src_oh;
    logic [NREG-1:0] w_dst_oh;
    logic [W-1:0]    w_bus;
    logic [NREG-1:0] w_load;

    // Unpack the flattened register readback and build the select decoders
    generate
        for (genvar i = 0; i < NREG; i++) begin : g_regsel
            assign w_regs[i]   = xif.reg_q[i*W +: W];
            assign w_src_oh[i] = (r_src == SELW'(i));
            assign w_dst_oh[i] = (r_dst == SELW'(i));
        end
    endgenerate

    assign w_src_q  = w_regs[r_src];
    assign w_dst_q  = w_regs[r_dst];

    // Ready only in IDLE and never while reset is asserted
    assign xif.req_ready = (r_state == IDLE) && rstn;
    assign w_accept      = xif.req_valid && xif.req_ready;

    // Next-state selection; SWAP takes the three-step path, all else one EXEC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (xif.req_op == OP_SWAP) ? SW1 : EXEC;
                end
            end
            EXEC:    w_state_nxt = IDLE;
            SW1:     w_state_nxt = SW2;
            SW2:     w_state_nxt = SW3;
            SW3:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus and strobe decode from registered state only (no req_* feedthrough)
    always_comb begin
        w_bus  = '0;
        w_load = '0;
        case (r_state)
            EXEC: begin
                w_load = w_dst_oh;
                case (r_op)
                    OP_MOVE:  w_bus = w_src_q;
                    OP_LOAD:  w_bus = r_imm;
                    OP_CLEAR: w_bus = '0;
                    default:  w_bus = '0;
                endcase
            end
            SW1: begin
                // Source value parked on the bus so it can be captured in tmp
                w_bus = w_src_q;
            end
            SW2: begin
                w_bus  = w_dst_q;
                w_load = w_src_oh;
            end
            SW3: begin
                w_bus  = r_tmp;
                w_load = w_dst_oh;
            end
            default: begin
                w_bus  = '0;
                w_load = '0;
            end
        endcase
    end

    assign xif.bus  = w_bus;
    assign xif.load = w_load;
    assign xif.done = r_done;

    // State, captured command fields, SWAP temporary and done pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_imm   <= '0;
            r_tmp   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // done marks the edge on which the final load of a command lands
            r_done  <= (r_state == EXEC) || (r_state == SW3);
            if (w_accept) begin
                r_op  <= xif.req_op;
                r_src <= xif.req_src;
                r_dst <= xif.req_dst;
                r_imm <= xif.req_imm;
            end
            if (r_state == SW1) begin
                r_tmp <= w_bus;
            end
        end
    end

    // Structural guarantees of the strobe decode
    a_load_onehot0 : assert property (@(posedge clk) $onehot0(xif.load));
    a_idle_no_load : assert property (@(posedge clk)
                                      (r_state == IDLE) |-> (xif.load == '0));
endmodule
`default_nettype wire

// File: tb/tb_reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_xfer_ctrl
//  Description : Self-checking bench for reg_xfer_ctrl. Owns a 4x4-bit
//                register bank fed by the controller's bus/load outputs and
//                scoreboards every load strobe against predicted writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_xfer_ctrl;
    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct {
        int         idx;
        logic [3:0] data;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       bank_clr;
    logic [3:0] bank [4];
    logic [3:0] m    [4];
    exp_t       exp_q [$];
    exp_t       e;
    logic [3:0] oh;
    int         vectors;
    int         miscompares;

    reg_xfer_ctrl_if #(.NREG(4), .W(4)) xif ();

    reg_xfer_ctrl #(.NREG(4), .W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .xif  (xif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register bank driven by the controller
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 4; i++) bank[i] <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) if (xif.load[i]) bank[i] <= xif.bus;
        end
    end
    assign xif.reg_q = {bank[3], bank[2], bank[1], bank[0]};

    // Scoreboard consumer: every load strobe must match the next predicted write
    always @(negedge clk) begin
        if (xif.load !== 4'b0000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_load: load=%b bus=%h, required no load", xif.load, xif.bus);
            end else begin
                e = exp_q.pop_front();
                oh = 4'b0000;
                oh[e.idx] = 1'b1;
                if (xif.load !== oh || xif.bus !== e.data) begin
                    miscompares++;
                    $display("FAIL sb_load: load=%b bus=%h, required load=%b bus=%h", xif.load, xif.bus, oh, e.data);
                end
                m[e.idx] = e.data;
            end
        end
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Present a command at a negedge, push its predicted writes, and return
    // at the negedge following the accepting edge with req_valid dropped.
    task automatic drive_cmd(input logic [1:0] op, input logic [1:0] src,
                             input logic [1:0] dst, input logic [3:0] imm);
        case (op)
            OP_MOVE:  exp_q.push_back('{int'(dst), m[src]});
            OP_LOAD:  exp_q.push_back('{int'(dst), imm});
            OP_CLEAR: exp_q.push_back('{int'(dst), 4'h0});
            default: begin
                exp_q.push_back('{int'(src), m[dst]});
                exp_q.push_back('{int'(dst), m[src]});
            end
        endcase
        xif.req_valid = 1'b1;
        xif.req_op    = op;
        xif.req_src   = src;
        xif.req_dst   = dst;
        xif.req_imm   = imm;
        @(posedge clk);
        @(negedge clk);
        xif.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (xif.done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [3:0] val);
        int n;
        drive_cmd(OP_LOAD, 2'd0, idx, val);
        wait_done(8, n);
    endtask

    task automatic test_reset;
        rstn          = 1'b0;
        bank_clr      = 1'b1;
        xif.req_valid = 1'b1;
        xif.req_op    = OP_LOAD;
        xif.req_src   = 2'd0;
        xif.req_dst   = 2'd1;
        xif.req_imm   = 4'hF;
        for (int i = 0; i < 4; i++) m[i] = 4'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (xif.load !== 4'b0000) begin miscompares++; $display("FAIL rst_load: load=%b, required 0000", xif.load); end
            vectors++;
            if (xif.bus !== 4'h0) begin miscompares++; $display("FAIL rst_bus: bus=%h, required 0", xif.bus); end
            vectors++;
            if (xif.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: done=%b, required 0", xif.done); end
            vectors++;
            if (xif.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: req_ready=%b, required 0", xif.req_ready); end
        end
        vectors++;
        if (dut.r_tmp !== 4'h0) begin miscompares++; $display("FAIL rst_tmp: tmp=%h, required 0", dut.r_tmp); end
        rstn          = 1'b1;
        bank_clr      = 1'b0;
        xif.req_valid = 1'b0;
        #1;
        vectors++;
        if (xif.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: req_ready=%b, required 1", xif.req_ready); end
        @(negedge clk);
        vectors++;
        if (xif.load !== 4'b0000 || xif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_accept: load=%b done=%b, required load=0000 done=0", xif.load, xif.done);
        end
    endtask

    task automatic test_load;
        vectors++;
        if (bank[2] !== 4'h0) begin miscompares++; $display("FAIL load_pre_r2: r2=%h, required 0", bank[2]); end
        drive_cmd(OP_LOAD, 2'd0, 2'd2, 4'hA);
        vectors++;
        if (xif.load !== 4'b0100 || xif.bus !== 4'hA) begin
            miscompares++;
            $display("FAIL load_exec: load=%b bus=%h, required load=0100 bus=a", xif.load, xif.bus);
        end
        vectors++;
        if (xif.done !== 1'b0 || xif.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_exec_hs: done=%b ready=%b, required done=0 ready=0", xif.done, xif.req_ready);
        end
        @(negedge clk);
        vectors++;
        if (xif.load !== 4'b0000 || xif.done !== 1'b1 || xif.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done: load=%b done=%b ready=%b, required load=0000 done=1 ready=1", xif.load, xif.done, xif.req_ready);
        end
        vectors++;
        if (bank[2] !== 4'hA) begin miscompares++; $display("FAIL load_r2: r2=%h, required a", bank[2]); end
        @(negedge clk);
        vectors++;
        if (xif.done !== 1'b0) begin miscompares++; $display("FAIL load_done_width: done=%b, required 0", xif.done); end
    endtask

    task automatic test_back_to_back;
        preload(2'd1, 4'h5);
        drive_cmd(OP_MOVE, 2'd1, 2'd3, 4'h0);
        @(negedge clk);
        vectors++;
        if (xif.done !== 1'b1 || xif.req_ready !== 1'b1 || bank[3] !== 4'h5) begin
            miscompares++;
            $display("FAIL b2b_move_done: done=%b ready=%b r3=%h, required done=1 ready=1 r3=5", xif.done, xif.req_ready, bank[3]);
        end
        drive_cmd(OP_CLEAR, 2'd0, 2'd1, 4'hF);
        vectors++;
        if (xif.load !== 4'b0010 || xif.bus !== 4'h0 || xif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_clear_exec: load=%b bus=%h done=%b, required load=0010 bus=0 done=0", xif.load, xif.bus, xif.done);
        end
        @(negedge clk);
        vectors++;
        if (xif.done !== 1'b1 || bank[1] !== 4'h0 || bank[3] !== 4'h5) begin
            miscompares++;
            $display("FAIL b2b_clear_done: done=%b r1=%h r3=%h, required done=1 r1=0 r3=5", xif.done, bank[1], bank[3]);
        end
    endtask

    task automatic test_swap;
        preload(2'd0, 4'h3);
        preload(2'd3, 4'hC);
        drive_cmd(OP_SWAP, 2'd0, 2'd3, 4'h0);
        vectors++;
        if (xif.load !== 4'b0000 || xif.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_sw1: load=%b ready=%b, required load=0000 ready=0", xif.load, xif.req_ready);
        end
        @(negedge clk);
        vectors++;
        if (xif.load !== 4'b0001 || xif.bus !== 4'hC) begin
            miscompares++;
            $display("FAIL swap_sw2: load=%b bus=%h, required load=0001 bus=c", xif.load, xif.bus);
        end
        @(negedge clk);
        vectors++;
        if (xif.load !== 4'b1000 || xif.bus !== 4'h3 || xif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_sw3: load=%b bus=%h done=%b, required load=1000 bus=3 done=0", xif.load, xif.bus, xif.done);
        end
        @(negedge clk);
        vectors++;
        if (xif.done !== 1'b1 || bank[0] !== 4'hC || bank[3] !== 4'h3) begin
            miscompares++;
            $display("FAIL swap_result: done=%b r0=%h r3=%h, required done=1 r0=c r3=3", xif.done, bank[0], bank[3]);
        end
    endtask

    task automatic test_swap_same;
        int nload;
        preload(2'd2, 4'h7);
        drive_cmd(OP_SWAP, 2'd2, 2'd2, 4'h0);
        // Hold a competing command; it must not be taken while the SWAP runs
        xif.req_valid = 1'b1;
        xif.req_op    = OP_LOAD;
        xif.req_dst   = 2'd0;
        xif.req_imm   = 4'hF;
        nload = 0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (xif.req_ready !== 1'b0) begin miscompares++; $display("FAIL swap_same_ready: cycle %0d req_ready=%b, required 0", k, xif.req_ready); end
            if (xif.load !== 4'b0000) nload++;
            @(negedge clk);
        end
        xif.req_valid = 1'b0;
        vectors++;
        if (nload !== 2) begin miscompares++; $display("FAIL swap_same_loads: %0d load cycles, required 2", nload); end
        vectors++;
        if (xif.done !== 1'b1 || bank[2] !== 4'h7 || bank[0] !== 4'hC) begin
            miscompares++;
            $display("FAIL swap_same_result: done=%b r2=%h r0=%h, required done=1 r2=7 r0=c", xif.done, bank[2], bank[0]);
        end
    endtask

    task automatic test_reset_mid_swap;
        int ndone;
        @(negedge clk);
        drive_cmd(OP_SWAP, 2'd0, 2'd3, 4'h0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if (xif.load !== 4'b0000 || xif.done !== 1'b0 || xif.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: load=%b done=%b ready=%b, required load=0000 done=0 ready=0", xif.load, xif.done, xif.req_ready);
        end
        vectors++;
        if (dut.r_tmp !== 4'h0) begin miscompares++; $display("FAIL abort_tmp: tmp=%h, required 0", dut.r_tmp); end
        vectors++;
        if (bank[0] !== 4'h3 || bank[3] !== 4'h3) begin
            miscompares++;
            $display("FAIL abort_regs: r0=%h r3=%h, required r0=3 r3=3", bank[0], bank[3]);
        end
        vectors++;
        if (exp_q.size() !== 1) begin
            miscompares++;
            $display("FAIL abort_pending: %0d writes pending, required 1", exp_q.size());
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        rstn = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (xif.done !== 1'b0) ndone++;
        end
        vectors++;
        if (ndone !== 0 || xif.req_ready !== 1'b1 || bank[3] !== 4'h3) begin
            miscompares++;
            $display("FAIL abort_after: done cycles=%0d ready=%b r3=%h, required 0 1 3", ndone, xif.req_ready, bank[3]);
        end
    endtask

    task automatic test_final_state;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bank[i] !== m[i]) begin miscompares++; $display("FAIL final_r%0d: %h, required %h", i, bank[i], m[i]); end
        end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL final_pending: %0d writes pending, required 0", exp_q.size()); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load();
        test_back_to_back();
        test_swap();
        test_swap_same();
        test_reset_mid_swap();
        test_final_state();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
